aes_round_ctrl: RTL and testbench

- Sequencing controller for the AES datapath: runs key expansion word-by-word, then steps the cipher or inverse-cipher rounds, and signals completion.
- Sits between the top-level wrapper/testbench handshake (start/done) and the AES round, key-expansion and state-register datapath.
- Caches expanded keys, so repeated blocks under the same key skip expansion.

---
 rtl/aes_ctrl_pkg.sv | 35 +++
 rtl/aes_kexp_seq.sv | 93 +++++++++
 rtl/aes_round_ctrl.sv | 166 ++++++++++++++++
 tb/tb_aes_round_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the AES round sequencing controller.
package aes_ctrl_pkg;

  // Controller FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEXP  = 3'd1,
    INIT  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Total number of expanded key words for a given round count.
  function automatic int f_nw(input int nr);
    return 4 * (nr + 1);
  endfunction

  // Number of words actually computed by expansion (first Nk come from the key).
  function automatic int f_kx(input int nk, input int nr);
    return f_nw(nr) - nk;
  endfunction

  // Default AES-128 geometry.
  localparam int NK_DEFAULT = 4;
  localparam int NR_DEFAULT = NK_DEFAULT + 6;
  localparam int NW = f_nw(NR_DEFAULT);
  localparam int KX = NW - NK_DEFAULT;

  // Round-key index: encrypt walks 0..Nr upward, decrypt walks Nr..0 downward.
  function automatic logic [3:0] f_rk_idx(input logic mode, input logic [3:0] r,
                                          input logic [3:0] nr);
    return mode ? (nr - r) : r;
  endfunction

endpackage

// File: rtl/aes_kexp_seq.sv
// Key-expansion word sequencer: walks word indices Nk..4*(Nr+1)-1 and tracks
// the position within each Nk-word group with a phase counter so that no
// divider or modulo is needed for the RotWord/SubWord/Rcon decode.
module aes_kexp_seq
  import aes_ctrl_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  output logic       o_en,
  output logic [5:0] o_idx,
  output logic       o_rot,
  output logic       o_sub,
  output logic [3:0] o_rcon,
  output logic       o_last
);

  localparam logic [5:0] IDX_FIRST = 6'(Nk);
  localparam logic [5:0] IDX_LAST  = 6'(f_nw(Nr) - 1);
  localparam logic [2:0] PH_MAX    = 3'(Nk - 1);
  localparam logic [2:0] PH_SUB    = 3'd4;
  localparam logic       SUB_EN    = (Nk == 8);

  logic       r_en;
  logic [5:0] r_idx;
  logic [2:0] r_phase;
  logic [3:0] r_rcon;
  logic       r_rot;
  logic       r_sub;
  logic       r_last;

  logic [5:0] w_idx_nxt;
  logic [2:0] w_phase_inc;
  logic       w_phase_wrap;

  assign w_idx_nxt    = r_idx + 6'd1;
  assign w_phase_inc  = r_phase + 3'd1;
  assign w_phase_wrap = (r_phase == PH_MAX);

  // Advance the word index and group phase; all decode flags are registered
  // one step ahead so they line up with the word they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en    <= 1'b0;
      r_idx   <= 6'd0;
      r_phase <= 3'd0;
      r_rcon  <= 4'd0;
      r_rot   <= 1'b0;
      r_sub   <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_en    <= 1'b1;
      r_idx   <= IDX_FIRST;
      r_phase <= 3'd0;
      r_rcon  <= 4'd1;
      r_rot   <= 1'b1;
      r_sub   <= 1'b0;
      r_last  <= (IDX_FIRST == IDX_LAST);
    end else if (r_en && !r_last) begin
      r_idx  <= w_idx_nxt;
      r_last <= (w_idx_nxt == IDX_LAST);
      if (w_phase_wrap) begin
        r_phase <= 3'd0;
        r_rcon  <= r_rcon + 4'd1;
        r_rot   <= 1'b1;
        r_sub   <= 1'b0;
      end else begin
        r_phase <= w_phase_inc;
        r_rot   <= 1'b0;
        r_sub   <= SUB_EN && (w_phase_inc == PH_SUB);
      end
    end else begin
      r_en    <= 1'b0;
      r_idx   <= 6'd0;
      r_phase <= 3'd0;
      r_rcon  <= 4'd0;
      r_rot   <= 1'b0;
      r_sub   <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_en   = r_en;
  assign o_idx  = r_idx;
  assign o_rot  = r_rot;
  assign o_sub  = r_sub;
  assign o_rcon = r_rcon;
  assign o_last = r_last;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencing controller: optional key expansion, whitening, Nr
// rounds, then a one-cycle done pulse. Expanded keys are remembered so that
// blocks under an unchanged key go straight to the rounds.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic       key_new,
  output logic       busy,
  output logic       done,
  output logic       kexp_en,
  output logic [5:0] kexp_idx,
  output logic       kexp_rot,
  output logic       kexp_sub,
  output logic [3:0] rcon_idx,
  output logic       state_en,
  output logic       init_add,
  output logic       mix_en,
  output logic       last_round,
  output logic [3:0] rk_idx
);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_round_ctrl: Nk must be 4, 6 or 8");
  end

  localparam logic [3:0] NR_W = 4'(Nr);

  state_t     r_state;
  logic [3:0] r_round;
  logic       r_mode;
  logic       r_keys_valid;
  logic       r_busy;
  logic       r_done;
  logic       r_state_en;
  logic       r_init_add;
  logic       r_mix_en;
  logic       r_last_round;
  logic [3:0] r_rk_idx;

  logic       w_kx_load;
  logic       w_kx_last;
  logic [3:0] w_round_inc;

  // Expansion is needed for a new key or when nothing valid is cached.
  assign w_kx_load   = (r_state == IDLE) && start && (key_new || !r_keys_valid);
  assign w_round_inc = r_round + 4'd1;

  aes_kexp_seq #(
    .Nk(Nk),
    .Nr(Nr)
  ) u_kexp_seq (
    .clk   (clk),
    .rst   (reset),
    .i_load(w_kx_load),
    .o_en  (kexp_en),
    .o_idx (kexp_idx),
    .o_rot (kexp_rot),
    .o_sub (kexp_sub),
    .o_rcon(rcon_idx),
    .o_last(w_kx_last)
  );

  // Controller FSM; outputs are registered from the state being entered so
  // they are valid for the whole cycle spent in that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_round      <= 4'd0;
      r_mode       <= 1'b0;
      r_keys_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_state_en   <= 1'b0;
      r_init_add   <= 1'b0;
      r_mix_en     <= 1'b0;
      r_last_round <= 1'b0;
      r_rk_idx     <= 4'd0;
    end else begin
      r_done       <= 1'b0;
      r_state_en   <= 1'b0;
      r_init_add   <= 1'b0;
      r_mix_en     <= 1'b0;
      r_last_round <= 1'b0;
      r_rk_idx     <= 4'd0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_busy <= 1'b1;
            if (key_new || !r_keys_valid) begin
              r_state <= KEXP;
            end else begin
              r_state    <= INIT;
              r_state_en <= 1'b1;
              r_init_add <= 1'b1;
              r_rk_idx   <= f_rk_idx(mode, 4'd0, NR_W);
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        KEXP: begin
          r_busy <= 1'b1;
          if (w_kx_last) begin
            r_keys_valid <= 1'b1;
            r_state      <= INIT;
            r_state_en   <= 1'b1;
            r_init_add   <= 1'b1;
            r_rk_idx     <= f_rk_idx(r_mode, 4'd0, NR_W);
          end else begin
            r_state <= KEXP;
          end
        end
        INIT: begin
          r_busy       <= 1'b1;
          r_state      <= ROUND;
          r_round      <= 4'd1;
          r_state_en   <= 1'b1;
          r_mix_en     <= (4'd1 < NR_W);
          r_last_round <= (4'd1 == NR_W);
          r_rk_idx     <= f_rk_idx(r_mode, 4'd1, NR_W);
        end
        ROUND: begin
          if (r_round == NR_W) begin
            r_state <= DONE;
            r_round <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_busy       <= 1'b1;
            r_round      <= w_round_inc;
            r_state_en   <= 1'b1;
            r_mix_en     <= (w_round_inc < NR_W);
            r_last_round <= (w_round_inc == NR_W);
            r_rk_idx     <= f_rk_idx(r_mode, w_round_inc, NR_W);
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_round <= 4'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign state_en   = r_state_en;
  assign init_add   = r_init_add;
  assign mix_en     = r_mix_en;
  assign last_round = r_last_round;
  assign rk_idx     = r_rk_idx;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: one Nk=4 and one Nk=8 instance,
// a block-level reference model checked every cycle, a vector table of
// whole-block expectations, directed corner sequences and random stimulus.
module tb_aes_round_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       kexp_en;
    logic [5:0] kexp_idx;
    logic       kexp_rot;
    logic       kexp_sub;
    logic [3:0] rcon_idx;
    logic       state_en;
    logic       init_add;
    logic       mix_en;
    logic       last_round;
    logic [3:0] rk_idx;
  } outs_t;

  typedef struct {
    int   d;
    logic mode;
    logic kn;
    int   lat;
    int   kx;
    int   rot;
    int   sub;
    int   rcon_max;
    int   init_rk;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset;
  logic  st [2];
  logic  md [2];
  logic  kn [2];
  outs_t g0, g1;

  int total = 0;
  int bad   = 0;

  // Reference model state: cycle position within the current block (0 = idle).
  int   m_c  [2];
  int   m_kx [2];
  logic m_mode [2];
  logic m_kv [2];

  always #5 clk = ~clk;

  aes_round_ctrl #(.Nk(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(st[0]), .mode(md[0]), .key_new(kn[0]),
    .busy(g0.busy), .done(g0.done), .kexp_en(g0.kexp_en), .kexp_idx(g0.kexp_idx),
    .kexp_rot(g0.kexp_rot), .kexp_sub(g0.kexp_sub), .rcon_idx(g0.rcon_idx),
    .state_en(g0.state_en), .init_add(g0.init_add), .mix_en(g0.mix_en),
    .last_round(g0.last_round), .rk_idx(g0.rk_idx)
  );

  aes_round_ctrl #(.Nk(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(st[1]), .mode(md[1]), .key_new(kn[1]),
    .busy(g1.busy), .done(g1.done), .kexp_en(g1.kexp_en), .kexp_idx(g1.kexp_idx),
    .kexp_rot(g1.kexp_rot), .kexp_sub(g1.kexp_sub), .rcon_idx(g1.rcon_idx),
    .state_en(g1.state_en), .init_add(g1.init_add), .mix_en(g1.mix_en),
    .last_round(g1.last_round), .rk_idx(g1.rk_idx)
  );

  function automatic int nk_of(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int nr_of(input int d);
    return nk_of(d) + 6;
  endfunction

  function automatic int kx_of(input int d);
    return 4 * (nr_of(d) + 1) - nk_of(d);
  endfunction

  function automatic outs_t gout(input int d);
    return (d == 0) ? g0 : g1;
  endfunction

  // Expected outputs for cycle c of a block with kx expansion cycles.
  function automatic outs_t exp_of(input int d, input int c, input int kx, input logic mode);
    outs_t e;
    int nk;
    int nr;
    int idx;
    int r;
    nk = nk_of(d);
    nr = nr_of(d);
    e  = '0;
    if (c >= 1) begin
      if (c <= kx) begin
        idx        = nk + c - 1;
        e.busy     = 1'b1;
        e.kexp_en  = 1'b1;
        e.kexp_idx = 6'(idx);
        e.kexp_rot = (idx % nk == 0);
        e.kexp_sub = (nk == 8) && (idx % nk == 4);
        e.rcon_idx = 4'(idx / nk);
      end else if (c == kx + 1) begin
        e.busy     = 1'b1;
        e.state_en = 1'b1;
        e.init_add = 1'b1;
        e.rk_idx   = mode ? 4'(nr) : 4'd0;
      end else if (c <= kx + 1 + nr) begin
        r            = c - kx - 1;
        e.busy       = 1'b1;
        e.state_en   = 1'b1;
        e.rk_idx     = mode ? 4'(nr - r) : 4'(r);
        e.mix_en     = (r < nr);
        e.last_round = (r == nr);
      end else if (c == kx + nr + 2) begin
        e.done = 1'b1;
      end
    end
    return e;
  endfunction

  // Block-level model: accept in idle, then count cycles through the block.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_c[d]  <= 0;
        m_kx[d] <= 0;
        m_kv[d] <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_c[d] == 0) begin
          if (st[d]) begin
            m_c[d]    <= 1;
            m_mode[d] <= md[d];
            m_kx[d]   <= (kn[d] || !m_kv[d]) ? kx_of(d) : 0;
          end
        end else if (m_c[d] >= m_kx[d] + nr_of(d) + 2) begin
          m_c[d] <= 0;
        end else begin
          m_c[d] <= m_c[d] + 1;
          if (m_kx[d] != 0 && m_c[d] == m_kx[d]) m_kv[d] <= 1'b1;
        end
      end
    end
  end

  task automatic cmp(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic check_all();
    outs_t e;
    outs_t g;
    for (int d = 0; d < 2; d++) begin
      e = exp_of(d, m_c[d], m_kx[d], m_mode[d]);
      g = gout(d);
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL cycle dut%0d c=%0d got=%h exp=%h", d, m_c[d], g, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Run one block on dut d and summarise what the outputs did.
  task automatic run_block(input int d, input logic mode, input logic knew,
                           output int lat, output int kcnt, output int rotc,
                           output int subc, output int rmax, output int irk);
    outs_t g;
    lat = -1; kcnt = 0; rotc = 0; subc = 0; rmax = 0; irk = -1;
    st[d] = 1'b1; md[d] = mode; kn[d] = knew;
    tick();
    st[d] = 1'b0; md[d] = $urandom_range(0, 1); kn[d] = $urandom_range(0, 1);
    for (int k = 0; k < 300; k++) begin
      g = gout(d);
      if (g.kexp_en) begin
        kcnt++;
        if (g.kexp_rot) rotc++;
        if (g.kexp_sub) subc++;
        if (int'(g.rcon_idx) > rmax) rmax = int'(g.rcon_idx);
      end
      if (g.init_add) irk = int'(g.rk_idx);
      if (g.done) begin
        lat = k;
        break;
      end
      tick();
    end
    tick();
  endtask

  vec_t tbl [6];

  initial begin
    int lat, kcnt, rotc, subc, rmax, irk;
    int found, ndone, first_k;
    int dk [$];

    tbl[0] = '{0, 1'b0, 1'b1, 51, 40, 10, 0, 10, 0};
    tbl[1] = '{0, 1'b1, 1'b0, 11, 0, 0, 0, 0, 10};
    tbl[2] = '{0, 1'b0, 1'b0, 11, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 1'b0, 1'b1, 67, 52, 7, 6, 7, 0};
    tbl[4] = '{1, 1'b1, 1'b0, 15, 0, 0, 0, 0, 14};
    tbl[5] = '{1, 1'b1, 1'b1, 67, 52, 7, 6, 7, 14};

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      st[d] = 1'b0; md[d] = 1'b0; kn[d] = 1'b0;
    end
    #1;
    cmp("reset_outs_d0", int'(g0), 0);
    cmp("reset_outs_d1", int'(g1), 0);
    @(negedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    tick();

    // Whole-block vectors.
    for (int i = 0; i < 6; i++) begin
      run_block(tbl[i].d, tbl[i].mode, tbl[i].kn, lat, kcnt, rotc, subc, rmax, irk);
      cmp($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      cmp($sformatf("vec%0d_kexp_cycles", i), kcnt, tbl[i].kx);
      cmp($sformatf("vec%0d_rot_words", i), rotc, tbl[i].rot);
      cmp($sformatf("vec%0d_sub_words", i), subc, tbl[i].sub);
      cmp($sformatf("vec%0d_rcon_max", i), rmax, tbl[i].rcon_max);
      cmp($sformatf("vec%0d_init_rk", i), irk, tbl[i].init_rk);
    end

    // Reset in the middle of round 5 clears everything, including cached keys.
    st[0] = 1'b1; md[0] = 1'b0; kn[0] = 1'b0;
    tick();
    st[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 30; k++) begin
      if (g0.state_en && !g0.init_add && g0.rk_idx == 4'd5) begin
        found = 1;
        break;
      end
      tick();
    end
    cmp("reach_round5", found, 1);
    reset = 1'b1;
    #1;
    cmp("midreset_outs_d0", int'(g0), 0);
    cmp("midreset_outs_d1", int'(g1), 0);
    @(negedge clk);
    check_all();
    reset = 1'b0;
    tick();
    run_block(0, 1'b0, 1'b0, lat, kcnt, rotc, subc, rmax, irk);
    cmp("post_reset_latency", lat, 51);
    cmp("post_reset_kexp_cycles", kcnt, 40);

    // start pulses during ROUND and the DONE cycle are ignored.
    st[0] = 1'b1; md[0] = 1'b0; kn[0] = 1'b0;
    tick();
    st[0] = 1'b0;
    ndone = 0; lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (k == 5) begin
        st[0] = 1'b1; kn[0] = 1'b1;
      end else begin
        st[0] = 1'b0;
      end
      if (g0.done) begin
        ndone++;
        lat = k;
        st[0] = 1'b1; kn[0] = 1'b1;
        tick();
        st[0] = 1'b0;
        break;
      end
      tick();
    end
    cmp("ignore_latency", lat, 11);
    cmp("idle_after_done_busy", int'(g0.busy), 0);
    for (int k = 0; k < 20; k++) begin
      if (g0.done || g0.busy) ndone++;
      tick();
    end
    cmp("single_done_pulse", ndone, 1);

    // start held high with cached keys: one block every Nr+3 cycles.
    st[0] = 1'b1; md[0] = 1'b1; kn[0] = 1'b0;
    tick();
    for (int k = 0; k < 70; k++) begin
      if (g0.done) dk.push_back(k);
      md[0] = $urandom_range(0, 1);
      tick();
    end
    st[0] = 1'b0;
    cmp("b2b_pulse_count", dk.size(), 5);
    first_k = (dk.size() > 0) ? dk[0] : -1;
    cmp("b2b_first_done", first_k, 11);
    for (int i = 1; i < dk.size(); i++) begin
      cmp($sformatf("b2b_period%0d", i), dk[i] - dk[i-1], 13);
    end
    for (int k = 0; k < 20; k++) tick();

    // Random stimulus against the model, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 2; d++) begin
        st[d] = ($urandom_range(0, 3) == 0);
        md[d] = $urandom_range(0, 1);
        kn[d] = ($urandom_range(0, 4) == 0);
      end
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
